seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the board's hex-to-7-segment driver.
- Samples a multiplexed, active-low 7-segment bus (segments + anodes) and decodes each lit pattern back to a hex nibble.
- Assembles all digits into one word and flags each completed frame.
- Used for loopback self-test of the display path and for on-chip monitoring of what the display shows.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_pattern_decode.sv | 47 ++++
 rtl/seg7_scan_capture.sv | 257 +++++++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment capture path:
//   - SEG_0..SEG_F, SEG_BLANK : active-low segment patterns, bit6=a ... bit0=g
//   - sample_class_t          : how many anodes are driven in one sample
//   - state_t                 : digit acquisition FSM states
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } sample_class_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational inverse of the hex-to-7-segment encoder.
// Ports:
//   pattern [6:0] in  : active-low segments, bit6=a ... bit0=g
//   nibble  [3:0] out : decoded hex value (0 for blank or bad patterns)
//   blank         out : pattern is all segments off
//   bad           out : pattern is not one of the sixteen hex glyphs
// -----------------------------------------------------------------------------
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       bad
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        nibble = 4'h0;
        blank  = 1'b0;
        bad    = 1'b0;
        case (pattern)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   bad    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// seg7_scan_capture
// Samples a multiplexed active-low 7-segment bus, decodes each stable digit
// and publishes a whole frame once every digit position has been seen.
// Ports:
//   clk, reset (async, active-high)
//   a_to_g [6:0]          in  : segments, active-low, bit6=a ... bit0=g
//   an [DIGITS-1:0]       in  : anodes, active-low, bit0 = rightmost digit
//   dp                    in  : decimal point, active-low
//   value [4*DIGITS-1:0]  out : digit i nibble at [4i+3:4i]
//   blank / bad           out : per-digit all-off / undecodable flags
//   frame_valid           out : pulse when value/blank/bad update
//   frame_timeout         out : pulse when a partial frame is dropped
//   err_multi             out : pulse on entry to a multi-anode sample
//   dp_out [DIGITS-1:0]   out : per-digit point lit (only with SEG7_CAP_DP_EN)
// Build option: define SEG7_CAP_DP_EN to capture the decimal point as well.
// -----------------------------------------------------------------------------
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 2**20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            a_to_g,
    input  logic [DIGITS-1:0]     an,
    input  logic                  dp,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     bad,
    output logic                  frame_valid,
    output logic                  frame_timeout,
    output logic                  err_multi
`ifdef SEG7_CAP_DP_EN
    ,
    output logic [DIGITS-1:0]     dp_out
`endif
);

    localparam int              FC_W        = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [7:0]      STABLE_LIM  = 8'(STABLE_CYCLES);
    localparam logic [FC_W-1:0] TIMEOUT_LIM = FC_W'(FRAME_TIMEOUT);
`ifdef SEG7_CAP_DP_EN
    localparam int              KEY_W       = DIGITS + 8;
`else
    localparam int              KEY_W       = DIGITS + 7;
`endif

    // ---------------- input synchroniser ----------------
    logic [6:0]        seg_meta, seg_sync;
    logic [DIGITS-1:0] an_meta, an_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_meta <= '1;
            seg_sync <= '1;
            an_meta  <= '1;
            an_sync  <= '1;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values on the same edge, giving a true two-stage pipeline.
            seg_meta <= a_to_g;
            seg_sync <= seg_meta;
            an_meta  <= an;
            an_sync  <= an_meta;
        end
    end

    logic [KEY_W-1:0] key, prev_key;

`ifdef SEG7_CAP_DP_EN
    logic dp_meta, dp_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_meta <= 1'b1;
            dp_sync <= 1'b1;
        end else begin
            dp_meta <= dp;
            dp_sync <= dp_meta;
        end
    end

    assign key = {dp_sync, an_sync, seg_sync};
`else
    // Point is not captured in this build; the input is intentionally idle.
    logic dp_unused;
    assign dp_unused = dp;
    assign key       = {an_sync, seg_sync};
`endif

    // ---------------- sample classification ----------------
    logic [DIGITS-1:0] an_low;
    sample_class_t     cls;

    assign an_low = ~an_sync;

    always_comb begin
        if (an_low == '0)
            cls = NONE;
        else if ((an_low & (an_low - DIGITS'(1))) == '0)
            cls = SINGLE;
        else
            cls = MULTI;
    end

    // ---------------- acquisition FSM ----------------
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (cls == SINGLE) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            SETTLE: begin
                if (cls != SINGLE)
                    state_d = IDLE;
                else if (key == prev_key)
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                else
                    cnt_d = 8'd1;
            end
            HOLD: begin
                if (key != prev_key) begin
                    if (cls == SINGLE) begin
                        state_d = SETTLE;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Capture on the sample that brings the count to the limit, so a
        // limit of 1 accepts the very first sample of a new digit.
        if (state_d == SETTLE && cnt_d >= STABLE_LIM) begin
            capture = 1'b1;
            state_d = HOLD;
        end
    end

    logic prev_multi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prev_key   <= '1;
            prev_multi <= 1'b0;
            err_multi  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_key   <= key;
            prev_multi <= (cls == MULTI);
            err_multi  <= (cls == MULTI) && !prev_multi;
        end
    end

    // ---------------- decode and shadow frame ----------------
    logic [3:0]          dec_nibble;
    logic                dec_blank, dec_bad;
    logic [4*DIGITS-1:0] shadow_value;
    logic [DIGITS-1:0]   shadow_blank, shadow_bad;

    seg7_pattern_decode u_decode (
        .pattern (seg_sync),
        .nibble  (dec_nibble),
        .blank   (dec_blank),
        .bad     (dec_bad)
    );

`ifdef SEG7_CAP_DP_EN
    logic [DIGITS-1:0] shadow_dp;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the shadow frame is a handful of flops, so it is reset like
            // any other state; a mid-frame reset then leaves nothing stale.
            shadow_value <= '0;
            shadow_blank <= '0;
            shadow_bad   <= '0;
`ifdef SEG7_CAP_DP_EN
            shadow_dp    <= '0;
`endif
        end else if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (an_low[i]) begin
                    shadow_value[4*i +: 4] <= dec_nibble;
                    shadow_blank[i]        <= dec_blank;
                    shadow_bad[i]          <= dec_bad;
`ifdef SEG7_CAP_DP_EN
                    shadow_dp[i]           <= ~dp_sync;
`endif
                end
            end
        end
    end

    // ---------------- frame completion and timeout ----------------
    logic              seen_full, timeout_hit, seen_clr;
    logic [DIGITS-1:0] seen, seen_d;
    logic [FC_W-1:0]   fcnt;

    assign seen_full   = &seen;
    // Completion takes priority over a timeout landing on the same cycle.
    assign timeout_hit = !seen_full && (seen != '0) && (fcnt == TIMEOUT_LIM);
    assign seen_clr    = seen_full || timeout_hit;
    assign seen_d      = (seen_clr ? '0 : seen) | (capture ? an_low : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen          <= '0;
            fcnt          <= '0;
            value         <= '0;
            blank         <= '0;
            bad           <= '0;
            frame_valid   <= 1'b0;
            frame_timeout <= 1'b0;
`ifdef SEG7_CAP_DP_EN
            dp_out        <= '0;
`endif
        end else begin
            seen          <= seen_d;
            frame_valid   <= seen_full;
            frame_timeout <= timeout_hit;
            // fcnt counts cycles since the first capture of the current frame.
            if (seen_d == '0)
                fcnt <= '0;
            else if (seen_clr)
                fcnt <= FC_W'(1);
            else
                fcnt <= fcnt + FC_W'(1);
            if (seen_full) begin
                value  <= shadow_value;
                blank  <= shadow_blank;
                bad    <= shadow_bad;
`ifdef SEG7_CAP_DP_EN
                dp_out <= shadow_dp;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_capture
// Directed bench for seg7_scan_capture with DIGITS=8, STABLE_CYCLES=4,
// FRAME_TIMEOUT=1000. Inputs change right after a falling edge; outputs are
// sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_seg7_scan_capture;

    localparam int DIGITS = 8;

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PA = 7'b0001000;
    localparam logic [6:0] PB = 7'b1100000;
    localparam logic [6:0] PC = 7'b0110001;
    localparam logic [6:0] PD = 7'b1000010;
    localparam logic [6:0] PE = 7'b0110000;
    localparam logic [6:0] PF = 7'b0111000;
    localparam logic [6:0] PBLANK = 7'b1111111;
    localparam logic [6:0] PJUNK  = 7'b1111110;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [6:0]            a_to_g = 7'h7F;
    logic [DIGITS-1:0]     an = '1;
    logic                  dp = 1'b1;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     blank;
    logic [DIGITS-1:0]     bad;
    logic                  frame_valid;
    logic                  frame_timeout;
    logic                  err_multi;
`ifdef SEG7_CAP_DP_EN
    logic [DIGITS-1:0]     dp_out;
`endif

    seg7_scan_capture #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (4),
        .FRAME_TIMEOUT (1000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .a_to_g        (a_to_g),
        .an            (an),
        .dp            (dp),
        .value         (value),
        .blank         (blank),
        .bad           (bad),
        .frame_valid   (frame_valid),
        .frame_timeout (frame_timeout),
        .err_multi     (err_multi)
`ifdef SEG7_CAP_DP_EN
        ,
        .dp_out        (dp_out)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Event monitor: cycle counter on rising edges, pulse counters on falling.
    int cyc = 0;
    int fv_cnt = 0;
    int ft_cnt = 0;
    int em_cnt = 0;
    int ft_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (frame_timeout === 1'b1) begin
            ft_cnt++;
            ft_cyc = cyc;
        end
        if (err_multi === 1'b1) em_cnt++;
    end

    logic [6:0] pats [8];

    task automatic idle(input int n);
        an     = '1;
        a_to_g = PBLANK;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int idx, input logic [6:0] pat, input int n);
        logic [DIGITS-1:0] one_hot;
        one_hot = DIGITS'(1) << idx;
        an      = ~one_hot;
        a_to_g  = pat;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) show(i, pats[i], 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fv0, ft0, em0, c0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_value", value, 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        check("rst_flags", {29'h0, frame_valid, frame_timeout, err_multi}, 32'h0);
        reset = 1'b0;
        idle(5);

        // ---- plain frame 1..8 ----
        pats = '{P1, P2, P3, P4, P5, P6, P7, P8};
        fv0 = fv_cnt;
        scan_range(0, 7);
        idle(10);
        check("t1_fv", 32'(fv_cnt - fv0), 32'd1);
        check("t1_value", value, 32'h87654321);
        check("t1_blank", 32'(blank), 32'h0);
        check("t1_bad", 32'(bad), 32'h0);

        // ---- letters, blank and undecodable ----
        pats = '{PF, PE, PD, PA, PB, PBLANK, PJUNK, PC};
        fv0 = fv_cnt;
        scan_range(0, 7);
        idle(10);
        check("t2_fv", 32'(fv_cnt - fv0), 32'd1);
        check("t2_value", value, 32'hC00BADEF);
        check("t2_blank", 32'(blank), 32'h20);
        check("t2_bad", 32'(bad), 32'h40);

        // ---- ghosting filter ----
        pats = '{P1, P2, P3, P4, P5, P6, P7, P8};
        fv0 = fv_cnt;
        scan_range(0, 6);
        for (int k = 0; k < 10; k++) show(7, (k % 2 == 0) ? P1 : P2, 2);
        check("t3_no_capture", 32'(fv_cnt - fv0), 32'd0);
        show(7, P3, 16);
        idle(10);
        check("t3_fv", 32'(fv_cnt - fv0), 32'd1);
        check("t3_value", value, 32'h37654321);

        // ---- multi-anode sample ----
        fv0 = fv_cnt;
        em0 = em_cnt;
        an     = 8'b11110011;
        a_to_g = P8;
        repeat (10) @(negedge clk);
        idle(10);
        check("t4_err_multi", 32'(em_cnt - em0), 32'd1);
        check("t4_no_capture", 32'(fv_cnt - fv0), 32'd0);
        check("t4_value_kept", value, 32'h37654321);
        pats = '{P7, P6, P5, P4, P3, P2, P1, P0};
        scan_range(0, 7);
        idle(10);
        check("t4_fv", 32'(fv_cnt - fv0), 32'd1);
        check("t4_value", value, 32'h01234567);

        // ---- frame timeout: digits 0..6 only ----
        pats = '{PF, PF, PF, PF, PF, PF, PF, PF};
        fv0 = fv_cnt;
        ft0 = ft_cnt;
        c0  = cyc;
        scan_range(0, 6);
        idle(1000);
        check("t5_ft", 32'(ft_cnt - ft0), 32'd1);
        // 2 sync + 4 stable samples to the capture edge, then 1000 cycles.
        check("t5_ft_time", 32'(ft_cyc - c0), 32'd1006);
        check("t5_no_fv", 32'(fv_cnt - fv0), 32'd0);
        check("t5_value", value, 32'h01234567);

        // ---- reset mid-frame ----
        pats = '{PE, PE, PE, PE, PE, PE, PE, PE};
        scan_range(0, 3);
        reset = 1'b1;
        #1;
        check("t6_rst_value", value, 32'h0);
        check("t6_rst_flags", {29'h0, frame_valid, frame_timeout, err_multi}, 32'h0);
        an     = '1;
        a_to_g = PBLANK;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(5);
        pats = '{P8, P9, PA, PB, PC, PD, PE, PF};
        fv0 = fv_cnt;
        scan_range(4, 7);
        idle(10);
        check("t6_partial", 32'(fv_cnt - fv0), 32'd0);
        scan_range(0, 3);
        idle(10);
        check("t6_fv", 32'(fv_cnt - fv0), 32'd1);
        check("t6_value", value, 32'hFEDCBA98);
        check("t6_bad", 32'(bad), 32'h0);

        check("end_err_multi_total", 32'(em_cnt), 32'd1);
        check("end_timeout_total", 32'(ft_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
